// File: rtl/pwm_multi.sv
// N-channel PWM with shared prescaler/period counter, double-buffered duty and edge/center modes.
// Optional dead-time complementary outputs are enabled by defining PWM_DEADTIME_EN.
module pwm_multi #(
  parameter int unsigned R      = 8,
  parameter int unsigned N      = 2,
  parameter int unsigned DVSR_W = 32
`ifdef PWM_DEADTIME_EN
  ,
  parameter int unsigned DT_W   = 8
`endif
) (
  input  logic                clk,
  input  logic                reset_n,
  input  logic                en,
  input  logic                mode,
  input  logic [DVSR_W-1:0]   dvsr,
  input  logic [N*(R+1)-1:0]  duty,
  input  logic                load,
`ifdef PWM_DEADTIME_EN
  input  logic [DT_W-1:0]     dead_time,
  output logic [N-1:0]        pwm_out_n,
`endif
  output logic [N-1:0]        pwm_out,
  output logic                period_tick,
  output logic                busy_pending
);

  localparam int unsigned DW = R + 1;
  localparam logic [R-1:0] M = {R{1'b1}};

  logic [DVSR_W-1:0] r_q;
  logic [R-1:0]      r_d;
  logic              r_dir;
  logic              r_mode;
  logic [N*DW-1:0]   r_pend;
  logic [N*DW-1:0]   r_act;
  logic              r_flag;
  logic              r_ptick;
  logic [N-1:0]      r_pwm;

  logic              w_tick;
  logic              w_boundary;
  logic [R-1:0]      w_d_nxt;
  logic              w_dir_nxt;
  logic [N-1:0]      w_raw;

  // Next counter value and direction; r_dir=1 means counting down.
  always_comb begin
    w_tick    = en && (r_q == dvsr);
    w_d_nxt   = r_d;
    w_dir_nxt = r_dir;
    if (!r_mode) begin
      w_d_nxt   = (r_d == M) ? '0 : r_d + R'(1);
      w_dir_nxt = 1'b0;
    end else if (!r_dir) begin
      if (r_d == M) begin
        w_d_nxt   = r_d - R'(1);
        w_dir_nxt = 1'b1;
      end else begin
        w_d_nxt   = r_d + R'(1);
      end
    end else begin
      if (r_d <= R'(1)) begin
        w_d_nxt   = '0;
        w_dir_nxt = 1'b0;
      end else begin
        w_d_nxt   = r_d - R'(1);
      end
    end
    w_boundary = w_tick && (w_d_nxt == '0);
  end

  // Raw per-channel compare at R+1 bits so duty >= 2^R saturates high.
  always_comb begin
    w_raw = '0;
    for (int i = 0; i < N; i++) begin
      w_raw[i] = en && ({1'b0, r_d} < r_act[i*DW +: DW]);
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_q     <= '0;
      r_d     <= '0;
      r_dir   <= 1'b0;
      r_mode  <= 1'b0;
      r_pend  <= '0;
      r_act   <= '0;
      r_flag  <= 1'b0;
      r_ptick <= 1'b0;
    end else begin
      if (en) begin
        r_q <= (r_q >= dvsr) ? '0 : r_q + DVSR_W'(1);
      end
      if (w_tick) begin
        r_d   <= w_d_nxt;
        r_dir <= w_dir_nxt;
      end
      if (w_boundary) begin
        r_mode <= mode;
      end
      r_ptick <= w_boundary;
      // A load coinciding with the boundary lands in pending and waits a full period.
      if (w_boundary && r_flag) begin
        r_act <= r_pend;
      end
      if (load) begin
        r_pend <= duty;
        r_flag <= 1'b1;
      end else if (w_boundary) begin
        r_flag <= 1'b0;
      end
    end
  end

`ifdef PWM_DEADTIME_EN
  logic [N-1:0]    r_prev;
  logic [N-1:0]    r_pwm_n;
  logic [DT_W-1:0] r_cnt     [N];
  logic [DT_W-1:0] w_cnt_nxt [N];

  // Any raw edge restarts the dead-time window; both legs stay low until it expires.
  always_comb begin
    for (int i = 0; i < N; i++) begin
      w_cnt_nxt[i] = '0;
      if (w_raw[i] != r_prev[i]) begin
        w_cnt_nxt[i] = dead_time;
      end else if (r_cnt[i] != '0) begin
        w_cnt_nxt[i] = r_cnt[i] - DT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_prev  <= '0;
      r_pwm   <= '0;
      r_pwm_n <= '0;
      for (int i = 0; i < N; i++) begin
        r_cnt[i] <= '0;
      end
    end else begin
      r_prev <= w_raw;
      for (int i = 0; i < N; i++) begin
        r_cnt[i]   <= w_cnt_nxt[i];
        r_pwm[i]   <= (w_cnt_nxt[i] == '0) && w_raw[i];
        r_pwm_n[i] <= (w_cnt_nxt[i] == '0) && en && !w_raw[i];
      end
    end
  end

  assign pwm_out_n = r_pwm_n;
`else
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_pwm <= '0;
    end else begin
      r_pwm <= w_raw;
    end
  end
`endif

  assign pwm_out      = r_pwm;
  assign period_tick  = r_ptick;
  assign busy_pending = r_flag;

endmodule

// File: tb/tb_pwm_multi.sv
// Directed self-checking bench for pwm_multi (R=8, N=2).
module tb_pwm_multi;

  logic        clk;
  logic        reset_n;
  logic        en;
  logic        mode;
  logic [31:0] dvsr;
  logic [17:0] duty;
  logic        load;
  logic [1:0]  pwm_out;
  logic        period_tick;
  logic        busy_pending;
`ifdef PWM_DEADTIME_EN
  logic [7:0]  dead_time;
  logic [1:0]  pwm_out_n;
`endif

  int vectors;
  int miscompares;

  pwm_multi #(.R(8), .N(2), .DVSR_W(32)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .en           (en),
    .mode         (mode),
    .dvsr         (dvsr),
    .duty         (duty),
    .load         (load),
`ifdef PWM_DEADTIME_EN
    .dead_time    (dead_time),
    .pwm_out_n    (pwm_out_n),
`endif
    .pwm_out      (pwm_out),
    .period_tick  (period_tick),
    .busy_pending (busy_pending)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #900000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  // Advance one clock and sample away from the edge.
  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Returns cycles until the next period_tick, or -1 on timeout.
  task automatic wait_tick(input int limit, output int n);
    n = 0;
    do begin
      step();
      n++;
    end while (!period_tick && n < limit);
    if (!period_tick) n = -1;
  endtask

  task automatic measure(input int cyc, output int h0, output int h1, output int t);
    h0 = 0; h1 = 0; t = 0;
    for (int i = 0; i < cyc; i++) begin
      step();
      if (pwm_out[0]) h0++;
      if (pwm_out[1]) h1++;
      if (period_tick) t++;
    end
  endtask

  task automatic load_duty(input int c0, input int c1);
    duty = {9'(c1), 9'(c0)};
    load = 1'b1;
    step();
    load = 1'b0;
  endtask

  task automatic test_reset();
    reset_n = 1'b0; en = 1'b0; mode = 1'b0; dvsr = '0; duty = '0; load = 1'b0;
`ifdef PWM_DEADTIME_EN
    dead_time = '0;
`endif
    repeat (3) step();
    vectors++;
    if (pwm_out !== 2'b00) begin
      miscompares++; $display("FAIL reset_pwm: got %b expected 00", pwm_out);
    end
    vectors++;
    if (period_tick !== 1'b0) begin
      miscompares++; $display("FAIL reset_tick: got %b expected 0", period_tick);
    end
    vectors++;
    if (busy_pending !== 1'b0) begin
      miscompares++; $display("FAIL reset_busy: got %b expected 0", busy_pending);
    end
    reset_n = 1'b1;
    step();
  endtask

  task automatic test_edge();
    int n, h0, h1, t;
    en = 1'b1;
    load_duty(128, 64);
    wait_tick(1000, n);
    vectors++;
    if (n < 0) begin
      miscompares++; $display("FAIL edge_first_tick: got timeout expected a tick");
    end
    vectors++;
    if (busy_pending !== 1'b0) begin
      miscompares++; $display("FAIL edge_busy_clear: got %b expected 0", busy_pending);
    end
    wait_tick(1000, n);
    vectors++;
    if (n != 256) begin
      miscompares++; $display("FAIL edge_period: got %0d expected 256", n);
    end
    measure(768, h0, h1, t);
    vectors++;
    if (h0 != 384 || h1 != 192 || t != 3) begin
      miscompares++;
      $display("FAIL edge_3periods: got h0=%0d h1=%0d ticks=%0d expected 384 192 3", h0, h1, t);
    end
  endtask

  task automatic test_dvsr();
    int n, h0, h1, t;
    dvsr = 32'd1;
    wait_tick(2000, n);
    vectors++;
    if (n != 512) begin
      miscompares++; $display("FAIL dvsr_period: got %0d expected 512", n);
    end
    measure(1024, h0, h1, t);
    vectors++;
    if (h0 != 512 || h1 != 256 || t != 2) begin
      miscompares++;
      $display("FAIL dvsr_duty: got h0=%0d h1=%0d ticks=%0d expected 512 256 2", h0, h1, t);
    end
    load_duty(0, 256);
    vectors++;
    if (busy_pending !== 1'b1) begin
      miscompares++; $display("FAIL dvsr_busy_set: got %b expected 1", busy_pending);
    end
    wait_tick(2000, n);
    vectors++;
    if (n != 511 || busy_pending !== 1'b0) begin
      miscompares++; $display("FAIL dvsr_load_apply: got n=%0d busy=%b expected 511 0", n, busy_pending);
    end
    measure(512, h0, h1, t);
    vectors++;
    if (h0 != 0 || h1 != 512) begin
      miscompares++; $display("FAIL duty_0_256: got h0=%0d h1=%0d expected 0 512", h0, h1);
    end
    load_duty(511, 0);
    wait_tick(2000, n);
    measure(512, h0, h1, t);
    vectors++;
    if (h0 != 512 || h1 != 0) begin
      miscompares++; $display("FAIL duty_511_0: got h0=%0d h1=%0d expected 512 0", h0, h1);
    end
    dvsr = 32'd0;
    wait_tick(1000, n);
    vectors++;
    if (n != 256) begin
      miscompares++; $display("FAIL dvsr_back_to_0: got %0d expected 256", n);
    end
  endtask

  task automatic test_shadow();
    int n, h0, h1, t, busy_cnt;
    load_duty(128, 64);
    wait_tick(1000, n);
    h0 = 0; busy_cnt = 0;
    duty = {9'd64, 9'd32};
    for (int i = 1; i <= 256; i++) begin
      step();
      if (pwm_out[0]) h0++;
      if (busy_pending) busy_cnt++;
      load = (i == 100);
    end
    vectors++;
    if (h0 != 128) begin
      miscompares++; $display("FAIL shadow_current: got %0d expected 128", h0);
    end
    vectors++;
    if (busy_cnt != 155 || period_tick !== 1'b1) begin
      miscompares++;
      $display("FAIL shadow_busy: got busy=%0d tick=%b expected 155 1", busy_cnt, period_tick);
    end
    measure(256, h0, h1, t);
    vectors++;
    if (h0 != 32 || h1 != 64) begin
      miscompares++; $display("FAIL shadow_next: got h0=%0d h1=%0d expected 32 64", h0, h1);
    end
  endtask

  task automatic test_back_to_back();
    int h0, h1, t;
    duty = {9'd64, 9'd128};
    for (int i = 1; i <= 256; i++) begin
      step();
      load = (i == 1);
    end
    h0 = 0;
    duty = {9'd64, 9'd32};
    for (int i = 1; i <= 256; i++) begin
      step();
      if (pwm_out[0]) h0++;
      load = (i == 255);
    end
    load = 1'b0;
    vectors++;
    if (h0 != 128 || busy_pending !== 1'b1) begin
      miscompares++;
      $display("FAIL b2b_before: got h0=%0d busy=%b expected 128 1", h0, busy_pending);
    end
    measure(256, h0, h1, t);
    vectors++;
    if (h0 != 128) begin
      miscompares++; $display("FAIL b2b_same_clk: got %0d expected 128", h0);
    end
    measure(256, h0, h1, t);
    vectors++;
    if (h0 != 32) begin
      miscompares++; $display("FAIL b2b_next_period: got %0d expected 32", h0);
    end
  endtask

  task automatic test_center();
    int n, h0, h1, t;
    mode = 1'b1;
    load_duty(64, 64);
    wait_tick(1000, n);
    vectors++;
    if (n != 255) begin
      miscompares++; $display("FAIL center_switch: got %0d expected 255", n);
    end
    wait_tick(1000, n);
    vectors++;
    if (n != 510) begin
      miscompares++; $display("FAIL center_period: got %0d expected 510", n);
    end
    measure(510, h0, h1, t);
    vectors++;
    if (h0 != 127 || h1 != 127 || t != 1) begin
      miscompares++;
      $display("FAIL center_high: got h0=%0d h1=%0d ticks=%0d expected 127 127 1", h0, h1, t);
    end
    n = 0;
    do begin
      step();
      n++;
      if (n == 100) mode = 1'b0;
    end while (!period_tick && n < 1000);
    vectors++;
    if (n != 510) begin
      miscompares++; $display("FAIL center_toggle_held: got %0d expected 510", n);
    end
    wait_tick(1000, n);
    vectors++;
    if (n != 256) begin
      miscompares++; $display("FAIL center_to_edge: got %0d expected 256", n);
    end
  endtask

  task automatic test_enable();
    int n, h0, h1, zbad, tpos;
    load_duty(200, 64);
    wait_tick(1000, n);
    vectors++;
    if (n != 255) begin
      miscompares++; $display("FAIL en_setup: got %0d expected 255", n);
    end
    h0 = 0; h1 = 0; zbad = 0; tpos = 0;
    for (int i = 1; i <= 276; i++) begin
      step();
      if (pwm_out[0]) h0++;
      if (pwm_out[1]) h1++;
      if (i > 50 && i <= 70 && pwm_out !== 2'b00) zbad++;
      if (period_tick && tpos == 0) tpos = i;
      if (i == 50) en = 1'b0;
      if (i == 70) en = 1'b1;
    end
    vectors++;
    if (zbad != 0) begin
      miscompares++; $display("FAIL en_low_outputs: got %0d nonzero samples expected 0", zbad);
    end
    vectors++;
    if (tpos != 276) begin
      miscompares++; $display("FAIL en_hold_period: got tick at %0d expected 276", tpos);
    end
    vectors++;
    if (h0 != 200 || h1 != 64) begin
      miscompares++; $display("FAIL en_resume: got h0=%0d h1=%0d expected 200 64", h0, h1);
    end
  endtask

  task automatic test_reset_mid();
    int h0, h1, t;
    repeat (10) step();
    load_duty(1, 1);
    vectors++;
    if (pwm_out !== 2'b11 || busy_pending !== 1'b1) begin
      miscompares++;
      $display("FAIL mid_pre: got pwm=%b busy=%b expected 11 1", pwm_out, busy_pending);
    end
    reset_n = 1'b0;
    #1;
    vectors++;
    if (pwm_out !== 2'b00 || busy_pending !== 1'b0 || period_tick !== 1'b0) begin
      miscompares++;
      $display("FAIL mid_async: got pwm=%b busy=%b tick=%b expected 00 0 0",
               pwm_out, busy_pending, period_tick);
    end
    #2;
    reset_n = 1'b1;
    measure(600, h0, h1, t);
    vectors++;
    if (h0 != 0 || h1 != 0 || t != 2) begin
      miscompares++;
      $display("FAIL mid_after: got h0=%0d h1=%0d ticks=%0d expected 0 0 2", h0, h1, t);
    end
  endtask

  initial begin
    vectors = 0;
    miscompares = 0;
    test_reset();
    test_edge();
    test_dvsr();
    test_shadow();
    test_back_to_back();
    test_center();
    test_enable();
    test_reset_mid();
    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/pwm_multi.md
Name: pwm_multi

Overview:
- N-channel PWM generator; parametrised successor to the single-channel pwm block. Drives the motor driver inputs of the wall follower, one channel per motor or direction leg.
- Shared prescaler and period counter for all channels, with a per-channel duty compare.
- Adds double-buffered duty registers, so updates are glitch-free.
- Adds a run-time select between edge-aligned and center-aligned counting.

Parameters:
- R, 8: counter resolution in bits; period base M = 2^R - 1.
- N, 2: number of PWM channels.
- DVSR_W, 32: prescaler divisor width.

Ports:
- clk  in  1  system clock
- reset_n  in  1  asynchronous active-low reset
- en  in  1  run enable; 0 freezes all counters and forces outputs low
- mode  in  1  0 = edge-aligned, 1 = center-aligned
- dvsr  in  DVSR_W  prescaler divisor; counter advances every dvsr+1 clocks
- duty  in  N*(R+1)  packed per-channel duty; channel i at [i*(R+1) +: R+1]
- load  in  1  1-cycle strobe; captures duty into the pending registers
- pwm_out  out  N  registered PWM outputs
- period_tick  out  1  1-clk pulse at each period start
- busy_pending  out  1  high while a captured duty has not yet been applied

Behaviour:
- Reset (async, reset_n=0), all registers cleared:
  - prescaler q=0, counter d=0, direction=up.
  - pending duty=0, active duty=0, pending flag=0.
  - pwm_out=0, period_tick=0, busy_pending=0.
- Prescaler:
  - q counts 0..dvsr; tick asserted on the clk where q==dvsr, then q returns to 0.
  - dvsr=0 gives a tick every clk.
  - A dvsr change takes effect immediately; if q>dvsr, q clears on the next clk.
- Edge mode (mode=0), on each tick:
  - d counts 0,1,...,M, then wraps to 0.
  - Period = 2^R ticks.
- Center mode (mode=1), on each tick:
  - d counts 0,1,...,M,M-1,...,1, then returns to 0.
  - Direction flips at d==M and at d==0.
  - Period = 2M ticks.
- Mode change:
  - Sampled only at the period boundary.
  - A change elsewhere is held until the next boundary.
- Period boundary:
  - Defined as the tick on which d becomes 0.
  - period_tick pulses the following clk, 1 clk wide.
- Compare:
  - Each clk, pwm_out[i] <= en & (d < active_duty[i]), compared at R+1-bit width.
  - Output latency: 1 clk after d changes.
  - duty=0: output constantly 0.
  - duty >= 2^R: output constantly 1 (100%); values up to 2^(R+1)-1 are legal and saturate to 100%.
- Double buffering:
  - load=1 copies duty into pending and sets the pending flag.
  - At the period boundary with the flag set, pending is copied to active and the flag clears.
  - load on the same clk as the boundary: that load is captured into pending and applied at the next boundary, not the current one.
  - Repeated loads within one period: the last one wins.
  - busy_pending = pending flag.
- en=0:
  - q, d and direction hold their values.
  - pwm_out = 0 (registered).
  - load is still accepted.
  - Counting resumes from the held state when en returns to 1.
- Reset asserted mid-period: all outputs drop to 0 asynchronously; pending data is lost.

Optional Feature:
- Macro: PWM_DEADTIME_EN.
- Defined:
  - Adds parameter DT_W (default 8) and input dead_time[DT_W-1:0].
  - Adds output pwm_out_n[N-1:0], the complement of pwm_out.
  - On every edge of the raw compare result, both pwm_out[i] and pwm_out_n[i] are held low for dead_time clks before the newly active leg rises.
  - A raw pulse shorter than dead_time is suppressed entirely on both legs.
  - dead_time=0 gives exact complements.
  - Reset value of pwm_out_n is 0.
- Not defined: no extra ports or logic; behaviour exactly as above.

Test Plan:
- R=8, N=2, dvsr=0, mode=0, duty={ch1=64, ch0=128} plus load, run 3 periods:
  - period_tick every 256 clks.
  - ch0 high 128 / low 128 clks; ch1 high 64 / low 192 clks.
- Same setup with dvsr=1:
  - Period 512 clks; ch0 high 256 clks.
  - duty=0 gives constant 0; duty=256 and duty=511 give constant 1.
- Shadow update: ch0 starts at 128; load ch0=32 at d=100:
  - Current period keeps the 128-tick high time.
  - Next period shows 32 ticks high.
  - busy_pending is high from the load clk until the boundary.
- Same-clk load and boundary: ch0 starts at 128; load ch0=32 exactly on the boundary tick:
  - The new period still shows 128 ticks high.
  - 32 appears one period later.
- Center mode, dvsr=0, duty ch0=64, mode=1:
  - Period 510 clks.
  - ch0 high 127 clks centered on d=0 (d=1..63 on the down-count, then 0..63 on the up-count).
  - A mode toggle mid-period takes effect only at the next boundary.
- Run with ch0 duty=200 and ch1 duty=64:
  - en=0 at d=50 gives outputs 0 and d held at 50 for 20 clks; en=1 resumes from d=51.
  - reset_n pulsed low mid-period gives all outputs 0 immediately and active duty 0 after release.
  - With PWM_DEADTIME_EN, dead_time=4: a 4-clk both-low gap at every transition.
